lsu_mem_master: RTL and testbench

//  Load/store initiator between core execute stage and data_memory (word array, comb read, write on clk).

---
 rtl/lsu_mem_master.sv | 176 +++++++++++++++++
 tb/tb_lsu_mem_master.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master.sv
// Load/store initiator for a plain 32-bit word memory; sub-word stores are read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to report misaligned H/W accesses as errors instead of aligning them.
module lsu_mem_master #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RESP
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_e      state_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_lo_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wd_q;

  logic        req_err_d;
  logic [31:0] word_idx_d;
  logic [7:0]  byte_d;
  logic [15:0] half_d;
  logic [31:0] load_d;
  logic [31:0] merge_d;

  always_comb begin
    if (req_we) begin
      req_err_d = !(req_funct3 inside {F3_B, F3_H, F3_W});
    end else begin
      req_err_d = !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    end
`ifdef LSU_MISALIGN_TRAP_EN
    if ((req_funct3[1:0] == 2'b01 && req_addr[0]) ||
        (req_funct3 == F3_W && req_addr[1:0] != 2'b00)) begin
      req_err_d = 1'b1;
    end
`endif
  end

  assign word_idx_d = {2'b00, req_addr[31:2]} % DEPTH;

  // Half lanes use only lane_q[1] and word accesses ignore the lane, which aligns misaligned requests.
  always_comb begin
    case (lane_q)
      2'd0:    byte_d = mem_rd[7:0];
      2'd1:    byte_d = mem_rd[15:8];
      2'd2:    byte_d = mem_rd[23:16];
      default: byte_d = mem_rd[31:24];
    endcase
    half_d = lane_q[1] ? mem_rd[31:16] : mem_rd[15:0];

    case (f3_q)
      F3_B:    load_d = {{24{byte_d[7]}}, byte_d};
      F3_H:    load_d = {{16{half_d[15]}}, half_d};
      F3_BU:   load_d = {24'b0, byte_d};
      F3_HU:   load_d = {16'b0, half_d};
      default: load_d = mem_rd;
    endcase

    merge_d = mem_rd;
    if (f3_q == F3_B) begin
      case (lane_q)
        2'd0:    merge_d[7:0]   = wdata_lo_q[7:0];
        2'd1:    merge_d[15:8]  = wdata_lo_q[7:0];
        2'd2:    merge_d[23:16] = wdata_lo_q[7:0];
        default: merge_d[31:24] = wdata_lo_q[7:0];
      endcase
    end else if (f3_q == F3_H) begin
      if (lane_q[1]) merge_d[31:16] = wdata_lo_q;
      else           merge_d[15:0]  = wdata_lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      f3_q         <= '0;
      lane_q       <= '0;
      wdata_lo_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_addr_q   <= '0;
      mem_wd_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            we_q       <= req_we;
            f3_q       <= req_funct3;
            lane_q     <= req_addr[1:0];
            wdata_lo_q <= req_wdata[15:0];
            if (req_err_d) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else begin
              mem_addr_q <= word_idx_d;
              if (req_we && req_funct3 == F3_W) begin
                mem_wd_q <= req_wdata;
                state_q  <= S_WRITE;
              end else begin
                state_q <= S_READ;
              end
            end
          end
        end
        S_READ: begin
          if (we_q) begin
            mem_wd_q <= merge_d;
            state_q  <= S_WRITE;
          end else begin
            resp_rdata_q <= load_d;
            resp_valid_q <= 1'b1;
            state_q      <= S_RESP;
          end
        end
        S_WRITE: begin
          resp_rdata_q <= '0;
          resp_valid_q <= 1'b1;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Gated by rst so an RMW interrupted by reset never reaches memory.
  assign mem_we     = (state_q == S_WRITE) & rst;
  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wd     = mem_wd_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Randomized bench for lsu_mem_master against a word-array model of load/store semantics.
module tb_lsu_mem_master;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned AWB   = $clog2(DEPTH);

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic           ld_en = 1'b0;
  logic [AWB-1:0] ld_idx = '0;
  logic [31:0]    ld_val = '0;

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  lsu_mem_master #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld_en) mem[ld_idx] <= ld_val;
    else if (mem_we && mem_addr < DEPTH) mem[mem_addr[AWB-1:0]] <= mem_wd;
  end

  assign mem_rd = (mem_addr < DEPTH) ? mem[mem_addr[AWB-1:0]] : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, output logic err, output logic [31:0] rdata,
                                output logic [31:0] new_word, output int lat, output int nwe,
                                output int we_cyc);
    int unsigned idx, sh_b, sh_h;
    logic [31:0] word, b, h;
    logic legal, misal;
    idx   = (addr >> 2) % DEPTH;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    misal = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    misal = ((f3 == 3'd1 || f3 == 3'd5) && addr[0]) || (f3 == 3'd2 && addr[1:0] != 2'b00);
`endif
    err      = !legal || misal;
    word     = ref_mem[idx];
    sh_b     = 8 * int'(addr[1:0]);
    sh_h     = 16 * int'(addr[1]);
    b        = (word >> sh_b) & 32'hFF;
    h        = (word >> sh_h) & 32'hFFFF;
    new_word = word;
    rdata    = '0;
    nwe      = 0;
    we_cyc   = 0;
    if (err) begin
      lat = 1;
    end else if (!we) begin
      lat = 2;
      case (f3)
        3'd0:    rdata = (b >= 128)   ? b + 32'hFFFF_FF00 : b;
        3'd4:    rdata = b;
        3'd1:    rdata = (h >= 32768) ? h + 32'hFFFF_0000 : h;
        3'd5:    rdata = h;
        default: rdata = word;
      endcase
    end else begin
      nwe = 1;
      case (f3)
        3'd2: begin new_word = wd; lat = 2; we_cyc = 1; end
        3'd0: begin
          new_word = (word & ~(32'hFF << sh_b)) | ((wd & 32'hFF) << sh_b);
          lat = 3; we_cyc = 2;
        end
        default: begin
          new_word = (word & ~(32'hFFFF << sh_h)) | ((wd & 32'hFFFF) << sh_h);
          lat = 3; we_cyc = 2;
        end
      endcase
    end
  endfunction

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input string tag, output logic [31:0] got);
    logic        e_err;
    logic [31:0] e_rd, e_new, waddr, first_addr;
    int          e_lat, e_nwe, e_wcyc, lat, nwe, wcyc, hold;
    int unsigned idx;
    model(we, f3, addr, wd, e_err, e_rd, e_new, e_lat, e_nwe, e_wcyc);
    idx = (addr >> 2) % DEPTH;
    @(negedge clk);
    chk({tag, ".ready"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; nwe = 0; wcyc = 0; waddr = '0; first_addr = '0;
    for (int cyc = 1; cyc <= 8 && lat == 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) first_addr = mem_addr;
      if (mem_we) begin nwe++; wcyc = cyc; waddr = mem_addr; end
      if (resp_valid) lat = cyc;
      req_valid  = 1'($urandom);
      req_we     = 1'($urandom);
      req_funct3 = 3'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
    end
    req_valid = 1'b0;
    got = resp_rdata;
    chk({tag, ".lat"},   lat, e_lat);
    chk({tag, ".err"},   {31'b0, resp_err}, {31'b0, e_err});
    chk({tag, ".rdata"}, resp_rdata, e_rd);
    chk({tag, ".nwe"},   nwe, e_nwe);
    if (e_nwe > 0) begin
      chk({tag, ".wecyc"}, wcyc, e_wcyc);
      chk({tag, ".waddr"}, waddr, idx);
    end
    if (!e_err) chk({tag, ".addr"}, first_addr, idx);
    hold = int'($urandom_range(0, 2));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk({tag, ".hold_v"}, {31'b0, resp_valid}, 32'd1);
      chk({tag, ".hold_d"}, resp_rdata, e_rd);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk({tag, ".done_v"},  {31'b0, resp_valid}, 32'd0);
    chk({tag, ".done_r"},  {31'b0, req_ready}, 32'd1);
    chk({tag, ".done_d"},  resp_rdata, 32'd0);
    chk({tag, ".done_e"},  {31'b0, resp_err}, 32'd0);
    if (e_nwe > 0) ref_mem[idx] = e_new;
    chk({tag, ".mem"}, mem[idx], ref_mem[idx]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, w, a;
    rst = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      @(negedge clk);
      w = (i == 5) ? 32'h8899_AABB : $urandom;
      ld_en = 1'b1; ld_idx = AWB'(i); ld_val = w; ref_mem[i] = w;
    end
    @(negedge clk);
    ld_en = 1'b0;
    @(posedge clk); #1;
    chk("rst.ready", {31'b0, req_ready}, 32'd1);
    chk("rst.valid", {31'b0, resp_valid}, 32'd0);
    chk("rst.err",   {31'b0, resp_err}, 32'd0);
    chk("rst.rdata", resp_rdata, 32'd0);
    chk("rst.we",    {31'b0, mem_we}, 32'd0);
    chk("rst.addr",  mem_addr, 32'd0);
    chk("rst.wd",    mem_wd, 32'd0);
    rst = 1'b1;

    do_req(1'b0, 3'b010, 32'h14, 32'h0, "lw", r);  chk("lw.const",  r, 32'h8899_AABB);
    do_req(1'b0, 3'b000, 32'h15, 32'h0, "lb", r);  chk("lb.const",  r, 32'hFFFF_FFAA);
    do_req(1'b0, 3'b100, 32'h15, 32'h0, "lbu", r); chk("lbu.const", r, 32'h0000_00AA);
    do_req(1'b0, 3'b001, 32'h16, 32'h0, "lh", r);  chk("lh.const",  r, 32'hFFFF_8899);
    do_req(1'b0, 3'b101, 32'h16, 32'h0, "lhu", r); chk("lhu.const", r, 32'h0000_8899);
    do_req(1'b1, 3'b000, 32'h17, 32'h1234_5677, "sb", r);
    chk("sb.const", mem[5], 32'h7799_AABB);
    do_req(1'b1, 3'b010, 32'h14, 32'hCAFE_F00D, "sw", r);
    do_req(1'b0, 3'b010, 32'h16, 32'h0, "lw_mis", r);
    do_req(1'b0, 3'b111, 32'h14, 32'h0, "f3_111", r); chk("f3_111.const", r, 32'h0);
    do_req(1'b1, 3'b100, 32'h18, 32'hFFFF_FFFF, "st_1xx", r);
    do_req(1'b0, 3'b010, 32'h14 + 4 * DEPTH, 32'h0, "wrap", r);
    chk("wrap.const", r, 32'hCAFE_F00D);

    // Reset arrives while the RMW of a half store sits in its write cycle.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h22; req_wdata = 32'h0000_5A5A;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rmw.we_pre", {31'b0, mem_we}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rmw.we_rst", {31'b0, mem_we}, 32'd0);
    @(posedge clk); #1;
    chk("rmw.ready", {31'b0, req_ready}, 32'd1);
    chk("rmw.valid", {31'b0, resp_valid}, 32'd0);
    chk("rmw.mem",   mem[8], ref_mem[8]);
    rst = 1'b1;

    for (int t = 0; t < 200; t++) begin
      a = ($urandom_range(0, 3) == 0) ? $urandom : {20'b0, 12'($urandom)};
      do_req(1'($urandom), 3'($urandom), a, $urandom, "rnd", r);
    end

    for (int i = 0; i < int'(DEPTH); i++) chk("final.mem", mem[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
